// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcodes, ALUOp encodings and the control bundle type
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;

    typedef struct packed {
        logic       regwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       beq;
        logic       bne;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decoder
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1
) (
    input  logic [5:0]   op,
    input  logic         valid,
    output ctrl_bundle_t bundle,
    output logic         uses_rt,
    output logic         jump,
    output logic         illegal
);

    logic is_jump;
    logic known;

    always_comb begin
        bundle  = BUBBLE;
        uses_rt = 1'b0;
        is_jump = 1'b0;
        known   = 1'b1;
        case (op)
            OP_RTYPE: begin
                bundle.regwrite = 1'b1;
                bundle.regdst   = 1'b1;
                bundle.aluop    = ALU_FUNCT;
                uses_rt         = 1'b1;
            end
            OP_ADDI: begin
                bundle.regwrite = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.aluop    = ALU_ADD;
            end
            OP_ORI: begin
                bundle.regwrite = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.aluop    = ALU_OR;
            end
            OP_SLTI: begin
                bundle.regwrite = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.aluop    = ALU_SLT;
            end
            OP_LW: begin
                bundle.regwrite = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.memread  = 1'b1;
                bundle.memtoreg = 1'b1;
                bundle.aluop    = ALU_ADD;
            end
            OP_SW: begin
                bundle.alusrc   = 1'b1;
                bundle.memwrite = 1'b1;
                bundle.aluop    = ALU_ADD;
                uses_rt         = 1'b1;
            end
            OP_BEQ: begin
                bundle.beq   = 1'b1;
                bundle.aluop = ALU_SUB;
                uses_rt      = 1'b1;
            end
            OP_BNE: begin
                bundle.bne   = 1'b1;
                bundle.aluop = ALU_SUB;
                uses_rt      = 1'b1;
            end
            OP_J: begin
                if (EN_JUMP) is_jump = 1'b1;
                else         known   = 1'b0;
            end
            default: known = 1'b0;
        endcase
    end

    assign jump    = valid & is_jump;
    assign illegal = valid & ~known;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined control: decode, ID/EX-EX/MEM-MEM/WB control regs, load-use stall
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 3,
    parameter int REG_ADDR_W = 5,
    parameter bit EN_JUMP    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5:0]            instr_op_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  jump_o,
    output logic                  illegal_o,
    output logic [ALUOP_W-1:0]    ex_aluop_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_regdst_o,
    output logic                  ex_brancheq_o,
    output logic                  ex_branchne_o,
    output logic                  mem_memread_o,
    output logic                  mem_memwrite_o,
    output logic                  wb_regwrite_o,
    output logic                  wb_memtoreg_o
);

    ctrl_bundle_t id_bundle;
    logic         id_uses_rt;

    ctrl_decode #(.EN_JUMP(EN_JUMP)) u_decode (
        .op      (instr_op_i),
        .valid   (id_valid_i),
        .bundle  (id_bundle),
        .uses_rt (id_uses_rt),
        .jump    (jump_o),
        .illegal (illegal_o)
    );

    ctrl_bundle_t          idex_bundle;
    logic [REG_ADDR_W-1:0] idex_rt;
    logic                  idex_valid;
    logic                  exmem_memread, exmem_memwrite, exmem_regwrite, exmem_memtoreg, exmem_valid;
    logic                  memwb_regwrite, memwb_memtoreg, memwb_valid;
    logic                  load_use;

    // A load targeting $0 writes nothing, so it never blocks a consumer.
    assign load_use = id_valid_i & idex_valid & idex_bundle.memread & (idex_rt != '0) &
                      ((idex_rt == id_rs_i) | (id_uses_rt & (idex_rt == id_rt_i)));
    assign stall_o  = load_use & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || stall_o || !id_valid_i || illegal_o) begin
            idex_bundle <= BUBBLE;
            idex_rt     <= '0;
            idex_valid  <= 1'b0;
        end else begin
            idex_bundle <= id_bundle;
            idex_rt     <= id_rt_i;
            idex_valid  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || !idex_valid) begin
            exmem_memread  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_regwrite <= 1'b0;
            exmem_memtoreg <= 1'b0;
            exmem_valid    <= 1'b0;
        end else begin
            exmem_memread  <= idex_bundle.memread;
            exmem_memwrite <= idex_bundle.memwrite;
            exmem_regwrite <= idex_bundle.regwrite;
            exmem_memtoreg <= idex_bundle.memtoreg;
            exmem_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !exmem_valid) begin
            memwb_regwrite <= 1'b0;
            memwb_memtoreg <= 1'b0;
            memwb_valid    <= 1'b0;
        end else begin
            memwb_regwrite <= exmem_regwrite;
            memwb_memtoreg <= exmem_memtoreg;
            memwb_valid    <= 1'b1;
        end
    end

    assign ex_aluop_o     = ALUOP_W'(idex_bundle.aluop);
    assign ex_alusrc_o    = idex_bundle.alusrc;
    assign ex_regdst_o    = idex_bundle.regdst;
    assign ex_brancheq_o  = idex_bundle.beq;
    assign ex_branchne_o  = idex_bundle.bne;
    assign mem_memread_o  = exmem_memread;
    assign mem_memwrite_o = exmem_memwrite;
    assign wb_regwrite_o  = memwb_regwrite;
    assign wb_memtoreg_o  = memwb_memtoreg;

endmodule
